add_arbiter: RTL

Round-robin arbiter and sequencer for the shared unsigned adder datapath: N_REQ requesters each present an operand pair with a valid/ready handshake. One grant is issued per cycle, and the sum (DATA_WIDTH+1 bits, carry preserved) is returned through a single registered response channel tagged with the requester index. The block sits between the cocotb-driven requester agents and the single adder instance, so one adder serves several streams.

---
 rtl/add_arb_pkg.sv | 15 +
 rtl/add_arbiter_rr_arbiter.sv | 31 +++
 rtl/add_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the add_arbiter slice: response-register state and
// the requester-index width calculation.
package add_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_arbiter_rr_arbiter.sv
// Pure combinational round-robin picker: the first set req bit at or above ptr,
// with wrap-around, wins. Reports a one-hot grant, its index and whether anything won.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin front end for one shared adder with a single registered response slot.
// Define ADD_ARB_STATS_EN to add the stat_grants / stat_carries counters.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int N_REQ      = 4,
  localparam int ID_W       = id_width(N_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_a,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH:0]              rsp_sum,
  output logic [ID_W-1:0]                  rsp_id,
  input  logic                             rsp_ready
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [31:0]                      stat_grants,
  output logic [31:0]                      stat_carries
`endif
);

  typedef logic [DATA_WIDTH:0] sum_t;

  state_t          state_reg, state_next;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] rsp_id_reg;
  sum_t            rsp_sum_reg;
  sum_t            sum_next;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            can_accept;
  logic            take;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // The slot can take a new result if it is empty or is being drained this cycle.
  assign can_accept = (state_reg == EMPTY) | rsp_ready;
  assign take       = can_accept & grant_any & ~rst;
  assign req_ready  = take ? grant : '0;
  assign sum_next   = sum_t'(req_a[grant_idx]) + sum_t'(req_b[grant_idx]);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (take)
      state_next = FULL;
    else if (state_reg == FULL && rsp_ready)
      state_next = EMPTY;
  end

  always_comb begin
    rsp_valid = (state_reg == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum_reg <= '0;
      rsp_id_reg  <= '0;
      rr_ptr_reg  <= '0;
    end else if (take) begin
      rsp_sum_reg <= sum_next;
      rsp_id_reg  <= grant_idx;
      rr_ptr_reg  <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign rsp_sum = rsp_sum_reg;
  assign rsp_id  = rsp_id_reg;

`ifdef ADD_ARB_STATS_EN
  logic [31:0] stat_grants_reg;
  logic [31:0] stat_carries_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants_reg  <= '0;
      stat_carries_reg <= '0;
    end else if (take) begin
      stat_grants_reg <= stat_grants_reg + 32'd1;
      if (sum_next[DATA_WIDTH])
        stat_carries_reg <= stat_carries_reg + 32'd1;
    end
  end

  assign stat_grants  = stat_grants_reg;
  assign stat_carries = stat_carries_reg;
`endif

endmodule
